// File: rtl/attn_softmax_sched_if.sv
// Handshake bundle for the row-serial softmax scheduler: matrix intake,
// row issue to the shared softmax unit, result return, and matrix output.
interface attn_softmax_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
);
  localparam int ROW_W = DATA_WIDTH * TOKEN_NUM;
  localparam int A_W   = ROW_W * TOKEN_NUM;
  localparam int V_W   = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   A_in;
  logic [V_W-1:0]   V_in;

  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;

  logic             res_valid;
  logic [ROW_W-1:0] res_data;

  logic             out_valid;
  logic             out_ready;
  logic [A_W-1:0]   S_out;
  logic [V_W-1:0]   V_out;

  // environment side: upstream producer, softmax unit, downstream consumer
  modport master (
    output in_valid, A_in, V_in, row_ready, res_valid, res_data, out_ready,
    input  in_ready, row_valid, row_data, out_valid, S_out, V_out
  );

  // scheduler side
  modport slave (
    input  in_valid, A_in, V_in, row_ready, res_valid, res_data, out_ready,
    output in_ready, row_valid, row_data, out_valid, S_out, V_out
  );
endinterface

// File: rtl/attn_softmax_sched.sv
// Row-serial softmax scheduler: captures a score/value matrix pair, streams
// score rows through one shared row-softmax unit, reassembles the returned
// rows into S and presents S with the captured V downstream.

// One result-row slot of the normalized score matrix.
module attn_sm_row_slot #(
  parameter int ROW_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ROW_W-1:0] d,
  output logic [ROW_W-1:0] q
);
  // hold the row bit-exact until the next write or reset
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module attn_softmax_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  attn_softmax_sched_if.slave  bus,
  output logic                 busy,
  output logic                 err
);
  localparam int ROW_W = DATA_WIDTH * TOKEN_NUM;
  localparam int V_W   = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;
  localparam int CW    = $clog2(TOKEN_NUM) + 1;
  localparam logic [CW-1:0] LAST = CW'(TOKEN_NUM - 1);
  localparam logic [CW-1:0] FULL = CW'(TOKEN_NUM);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state;
  logic [CW-1:0]                  issue_cnt, ret_cnt;
  logic [TOKEN_NUM-1:0][ROW_W-1:0] a_buf;
  logic [TOKEN_NUM-1:0][ROW_W-1:0] s_q;
  logic [V_W-1:0]                 v_q;
  logic                           in_ready_q, row_valid_q, out_valid_q, busy_q;

  logic                           row_acc, res_live, res_ok, res_bad;
  logic [CW-1:0]                  issued_eff, ret_nxt;
  logic [TOKEN_NUM-1:0]           s_we;

  // A result is legal only while a row is outstanding; a row accepted on
  // this same edge counts, which covers a combinational softmax unit.
  assign row_acc    = row_valid_q & bus.row_ready;
  assign issued_eff = issue_cnt + (row_acc ? ONE : '0);
  assign res_live   = (state == ISSUE) || (state == DRAIN);
  assign res_ok     = bus.res_valid & res_live & (ret_cnt < issued_eff);
  assign res_bad    = bus.res_valid & ~res_ok;
  assign ret_nxt    = ret_cnt + (res_ok ? ONE : '0);

  // per-row result slots, written in return order
  for (genvar r = 0; r < TOKEN_NUM; r++) begin : g_slot
    assign s_we[r] = res_ok && (ret_cnt == CW'(r));
    attn_sm_row_slot #(.ROW_W(ROW_W)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (s_we[r]),
      .d   (bus.res_data),
      .q   (s_q[r])
    );
  end

  // row being offered to the softmax unit; zero once every row is issued
  always_comb begin
    bus.row_data = '0;
    for (int r = 0; r < TOKEN_NUM; r++)
      if (issue_cnt == CW'(r)) bus.row_data = a_buf[r];
  end

  // control FSM with registered handshake outputs and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      a_buf       <= '0;
      v_q         <= '0;
      in_ready_q  <= 1'b0;
      row_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (res_bad) err     <= 1'b1;
      if (res_ok)  ret_cnt <= ret_nxt;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_buf       <= bus.A_in;
            v_q         <= bus.V_in;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            in_ready_q  <= 1'b0;
            row_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (row_acc) begin
            if (issue_cnt != FULL) issue_cnt <= issue_cnt + ONE;
            if (issue_cnt == LAST) begin
              row_valid_q <= 1'b0;
              if (ret_nxt == FULL) begin
                out_valid_q <= 1'b1;
                state       <= DONE;
              end else begin
                state       <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (ret_nxt == FULL) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.row_valid = row_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S_out     = s_q;
  assign bus.V_out     = v_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_attn_softmax_sched.sv
// Directed bench for attn_softmax_sched: a stand-in softmax unit (bitwise
// invert, latency 2 or combinational) plus hand-derived timing and data.
module tb_attn_softmax_sched;
  localparam int DW    = 16;
  localparam int TD    = 4;
  localparam int TN    = 8;
  localparam int ROW_W = DW * TN;
  localparam int A_W   = ROW_W * TN;
  localparam int V_W   = DW * TD * TN;
  localparam int W     = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  attn_softmax_sched_if #(.DATA_WIDTH(DW), .TOKEN_DIM(TD), .TOKEN_NUM(TN)) bus ();

  attn_softmax_sched #(.DATA_WIDTH(DW), .TOKEN_DIM(TD), .TOKEN_NUM(TN)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stand-in softmax unit: result = bitwise inverse of the row
  logic                     zl = 1'b0;
  logic                     spur = 1'b0;
  logic [ROW_W-1:0]         spur_data = '0;
  logic [1:0]               pv;
  logic [1:0][ROW_W-1:0]    pd;

  function automatic logic [ROW_W-1:0] xf(input logic [ROW_W-1:0] r);
    return ~r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[0], bus.row_valid & bus.row_ready & ~zl};
      pd <= {pd[0], xf(bus.row_data)};
    end
  end

  assign bus.res_valid = spur | (zl ? (bus.row_valid & bus.row_ready) : pv[1]);
  assign bus.res_data  = spur ? spur_data : (zl ? xf(bus.row_data) : pd[1]);

  // A element (r,c) = seed + r*16 + c
  function automatic logic [ROW_W-1:0] a_row(input int r, input int seed);
    logic [ROW_W-1:0] v;
    for (int c = 0; c < TN; c++) v[c*DW +: DW] = DW'(seed + r*16 + c);
    return v;
  endfunction

  // expected normalized row: every element inverted by the stand-in unit
  function automatic logic [ROW_W-1:0] s_row(input int r, input int seed);
    logic [ROW_W-1:0] v;
    for (int c = 0; c < TN; c++) v[c*DW +: DW] = ~DW'(seed + r*16 + c);
    return v;
  endfunction

  function automatic logic [V_W-1:0] v_mat(input int seed);
    logic [V_W-1:0] v;
    for (int i = 0; i < TD*TN; i++) v[i*DW +: DW] = DW'(16'h1000 + seed + i);
    return v;
  endfunction

  // Push one matrix and follow it to completion; cycle numbers count from
  // the capture edge (cycle 0). abort_at>=0 pulses rst after that many rows.
  task automatic run_matrix(input int seed, input logic [63:0] stall, input int hold,
                            input int abort_at,
                            output int ov_cyc, output int first_rv, output int last_rv);
    logic [A_W-1:0] a;
    logic [A_W-1:0] snap;
    int w, exp_idx;
    ov_cyc = -1; first_rv = -1; last_rv = -1; exp_idx = 0;
    for (int r = 0; r < TN; r++) a[r*ROW_W +: ROW_W] = a_row(r, seed);
    @(negedge clk);
    bus.A_in = a; bus.V_in = v_mat(seed); bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    chk("capture_wait", W'(w < 50), W'(1));
    for (int n = 1; n <= 100 && ov_cyc < 0; n++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.row_ready = (n < 64) ? !stall[n] : 1'b1;
      if (bus.row_valid) begin
        if (first_rv < 0) first_rv = n;
        last_rv = n;
        chk("row_data", W'(bus.row_data), W'(a_row(exp_idx, seed)));
        if (bus.row_ready) exp_idx++;
      end
      if (bus.out_valid) ov_cyc = n;
      if (abort_at >= 0 && exp_idx == abort_at) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        return;
      end
    end
    chk("out_valid_seen", W'(ov_cyc >= 0), W'(1));
    chk("busy_in_done", W'(busy), W'(1));
    chk("in_ready_in_done", W'(bus.in_ready), W'(0));
    for (int r = 0; r < TN; r++)
      chk("S_row", W'(bus.S_out[r*ROW_W +: ROW_W]), W'(s_row(r, seed)));
    chk("V_out", W'(bus.V_out), W'(v_mat(seed)));
    snap = bus.S_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("out_valid_held", W'(bus.out_valid), W'(1));
      chk("S_stable", W'(bus.S_out == snap), W'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after_out", W'(bus.in_ready), W'(1));
    chk("out_valid_after_out", W'(bus.out_valid), W'(0));
    chk("busy_after_out", W'(busy), W'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int ov, frv, lrv;
    logic [A_W-1:0] ra;
    bus.in_valid = 1'b0; bus.A_in = '0; bus.V_in = '0;
    bus.row_ready = 1'b1; bus.out_ready = 1'b0;

    // reset held over three edges with random inputs
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), W'(0));
      chk("rst_row_valid", W'(bus.row_valid), W'(0));
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_err", W'(err), W'(0));
      for (int k = 0; k < A_W/32; k++) ra[k*32 +: 32] = $urandom;
      bus.A_in = ra; bus.V_in = ra[V_W-1:0];
      bus.in_valid = 1'($urandom); bus.out_ready = 1'($urandom);
      bus.row_ready = 1'($urandom); spur = 1'($urandom);
      spur_data = ra[ROW_W-1:0];
    end
    chk("rst_S_lo", W'(bus.S_out[W-1:0]), W'(0));
    chk("rst_S_hi", W'(bus.S_out[A_W-1:W]), W'(0));
    chk("rst_V", W'(bus.V_out), W'(0));
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.row_ready = 1'b1; spur = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", W'(bus.in_ready), W'(1));
    chk("rel_busy", W'(busy), W'(0));

    // basic, latency 2
    run_matrix(0, 64'h0, 0, -1, ov, frv, lrv);
    chk("basic_first_rv", W'(frv), W'(1));
    chk("basic_last_rv", W'(lrv), W'(8));
    chk("basic_out_valid", W'(ov), W'(11));

    // row_ready low on cycles 2 and 5, output held 4 cycles
    run_matrix(16'h0100, 64'h24, 4, -1, ov, frv, lrv);
    chk("bp_last_rv", W'(lrv), W'(10));
    chk("bp_out_valid", W'(ov), W'(13));

    // combinational softmax unit
    zl = 1'b1;
    run_matrix(16'h0200, 64'h0, 0, -1, ov, frv, lrv);
    chk("zl_last_rv", W'(lrv), W'(8));
    chk("zl_out_valid", W'(ov), W'(9));
    zl = 1'b0;

    // result pulse with nothing outstanding
    @(negedge clk);
    spur = 1'b1; spur_data = '1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_err", W'(err), W'(1));
    run_matrix(16'h0300, 64'h0, 0, -1, ov, frv, lrv);
    chk("spur_out_valid", W'(ov), W'(11));
    chk("spur_err_sticky", W'(err), W'(1));

    // reset after three rows issued
    run_matrix(16'h0400, 64'h0, 0, 3, ov, frv, lrv);
    chk("mid_busy", W'(busy), W'(0));
    chk("mid_row_valid", W'(bus.row_valid), W'(0));
    chk("mid_in_ready", W'(bus.in_ready), W'(0));
    chk("mid_out_valid", W'(bus.out_valid), W'(0));
    chk("mid_err", W'(err), W'(0));
    chk("mid_S_row0", W'(bus.S_out[ROW_W-1:0]), W'(0));
    chk("mid_V", W'(bus.V_out), W'(0));
    run_matrix(16'h0500, 64'h0, 0, -1, ov, frv, lrv);
    chk("post_first_rv", W'(frv), W'(1));
    chk("post_last_rv", W'(lrv), W'(8));
    chk("post_out_valid", W'(ov), W'(11));
    chk("post_err", W'(err), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
